seven_seg_scan_ctrl: RTL and testbench
======================================

# seven_seg_scan_ctrl

Time-multiplexed scan controller for a common-anode 7-segment display bank. One hex-to-segment decoder and one segment bus are shared across `NUM_DIGITS` digits. The block steps through the digits at a fixed slot rate and inserts a blanking gap at each digit change to prevent ghosting. It double-buffers the displayed value and commits new values only at frame boundaries, so a display update never shows a mix of old and new digits.

## Interface
- `NUM_DIGITS`, 4: digits scanned; legal range 1..8.
- `REFRESH_DIV`, 50000: clock cycles per digit slot; must be ≥ `BLANK_CYCLES`+2.
- `BLANK_CYCLES`, 500: cycles at the start of each slot with all anodes off.
- `clk`, in, 1: single clock; all logic on its rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `value_in`, in, 4*NUM_DIGITS: hex nibbles; nibble 0 ([3:0]) is the rightmost digit.
- `digit_en_in`, in, NUM_DIGITS: per-digit enable captured with the value.
- `lz_suppress_in`, in, 1: leading-zero suppression captured with the value.
- `load`, in, 1: one-cycle strobe; captures `value_in`, `digit_en_in` and `lz_suppress_in` into the pending buffer.
- `seg_out`, out, [0:6]: segments a..g, active-low, registered.
- `an_out`, out, NUM_DIGITS: anode selects, active-low, registered; at most one bit low at any time.
- `frame_done`, out, 1: one-cycle pulse after the last slot of every frame.

## Operation
- Reset values: `seg_out`=7'b1111111; `an_out` all ones; `frame_done`=0; slot counter 0; digit index 0; FSM in BLANK; active buffer cleared (value 0, enables 0, lz 0), so the display is dark until the first commit; pending buffer cleared; `pend_valid`=0.
- FSM, one pass per slot:
  - BLANK: lasts `BLANK_CYCLES` cycles, then goes to SHOW.
  - SHOW: lasts `REFRESH_DIV`-`BLANK_CYCLES` cycles, then goes to BLANK, advancing the digit index. The index wraps from `NUM_DIGITS`-1 to 0.
- Slot counter: width $clog2(REFRESH_DIV). Counts 0..REFRESH_DIV-1 and wraps. BLANK while count < `BLANK_CYCLES`.
- In SHOW for digit d, the digit is visible when its active enable is 1 and it is not suppressed:
  - `an_out[d]`=0.
  - `seg_out` = decode(active nibble d).
- A disabled or suppressed digit drives `an_out` all ones and `seg_out` all ones, but still consumes its full slot, so brightness stays constant.
- Leading-zero suppression (active lz=1): digit d is suppressed if it and every digit above it are zero nibbles. Digit 0 is never suppressed.
- Decode, as a{..}g with 0 meaning lit:
  - 0 → 0000001, 1 → 1001111, 2 → 0010010, 3 → 0000110
  - 4 → 1001100, 5 → 0100100, 6 → 0100000, 7 → 0001111
  - 8 → 0000000, 9 → 0000100, A → 0001000, b → 1100000
  - C → 0110001, d → 1000010, E → 0110000, F → 0111000
- Load: on `load`=1, pending ← inputs and `pend_valid` ← 1. A second load before a commit overwrites the pending buffer; the last load wins.
- Frame boundary = the last cycle of digit `NUM_DIGITS`-1's slot. At that point, if `pend_valid`=1: active ← pending and `pend_valid` ← 0.
- Load on the boundary cycle: the previous pending contents commit, the new load lands in pending with `pend_valid`=1, and it commits at the next boundary.
- `rst` mid-operation: all state returns to reset values on the next edge and the pending load is discarded.

## Timing
- Outputs are registered with 1-cycle latency: `seg_out`, `an_out` and `frame_done` in cycle n reflect FSM state, counter and digit index of cycle n-1.
- Cycle 0 is the first cycle with `rst` low; slot 0 begins in cycle 0.
- Slot k occupies cycles [k*REFRESH_DIV, (k+1)*REFRESH_DIV).
- Anode low for cycles BLANK_CYCLES+1 .. REFRESH_DIV of the slot, relative to the slot start.
- `frame_done` is high in cycle NUM_DIGITS*REFRESH_DIV*f for f≥1 (cycle 0 excluded). Committed data is first visible in slot 0 of the following frame.
- Frame period: NUM_DIGITS*REFRESH_DIV cycles, exact; no gaps between frames.

## Structure
- Shared package `seven_seg_pkg`:
  - segment-pattern constants `SEG_BLANK`=7'b1111111 and `SEG_HEX[16]`;
  - FSM state typedef {BLANK, SHOW}.
- One sub-module: instantiate the existing `decoder_7_seg` (4-bit in, [0:6] active-low out) on the muxed active nibble. Blank override and the output register live in the controller.
- Leading-zero mask: combinational, computed from the active buffer.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset held for 5 cycles, then released with no load → `seg_out`=7'h7F, `an_out`=4'hF throughout; `frame_done` pulses at cycles 32 and 64.
- Load 16'h12AF, en=4'hF, lz=0 in cycle 3 → from cycle 32 onward:
  - slot 0 shows `an_out`=1110, `seg_out`=0111000 for 6 cycles after 2 blank cycles;
  - then 1101/0001000, 1011/0010010, 0111/1001111.
- Load 16'h0040, en=F, lz=1 → digits 3 and 2 dark; digit 1 shows 1001100; digit 0 shows 0000001.
- Load 16'h0000, en=F, lz=1 → only digit 0 lit, showing 0000001.
- Load 16'h1111 during slot 1 of a frame showing 16'h2222 → slots 1..3 still show 0010010; next frame shows 1001111.
- Loads of 16'h3333 then 16'h4444 in the same frame → only 4 is ever displayed.
- Load of 16'h5555 exactly on the boundary cycle → commits one frame later.
- `rst` pulsed for one cycle mid-slot 2 → next cycle outputs are blank; the display stays dark until a new load commits.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan controller.
// Segment patterns are a..g, active-low (0 = segment lit).
package seven_seg_pkg;

    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    localparam logic [0:6] SEG_HEX [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef enum logic {
        BLANK,
        SHOW
    } scan_state_e;

endpackage

// File: rtl/decoder_7_seg.sv
// Hex nibble to active-low a..g segment pattern.
module decoder_7_seg (
    input  logic [3:0] nibble,
    output logic [0:6] seg
);
    import seven_seg_pkg::*;

    always_comb begin
        seg = SEG_HEX[nibble];
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller: blank gap per digit slot, shared decoder,
// double-buffered display value committed only at frame boundaries.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   digit_en_in,
    input  logic                    lz_suppress_in,
    input  logic                    load,
    output logic [0:6]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_done
);
    import seven_seg_pkg::*;

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(NUM_DIGITS - 1);

    scan_state_e state;
    scan_state_e state_next;

    logic [CNT_W-1:0] slot_cnt;
    logic [DIG_W-1:0] digit;
    logic             slot_end;
    logic             blank_end;
    logic             boundary;

    logic [4*NUM_DIGITS-1:0] pend_value;
    logic [NUM_DIGITS-1:0]   pend_en;
    logic                    pend_lz;
    logic                    pend_valid;

    logic [4*NUM_DIGITS-1:0] act_value;
    logic [NUM_DIGITS-1:0]   act_en;
    logic                    act_lz;

    logic [NUM_DIGITS-1:0] lz_mask;
    logic [3:0]            cur_nibble;
    logic [0:6]            dec_seg;
    logic                  visible;
    logic [0:6]            seg_next;
    logic [NUM_DIGITS-1:0] an_next;

    assign slot_end  = (slot_cnt == CNT_LAST);
    assign blank_end = (slot_cnt == BLANK_LAST);
    assign boundary  = slot_end && (digit == DIG_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BLANK;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: BLANK for the first BLANK_CYCLES of a slot, SHOW for the rest
    always_comb begin
        state_next = state;
        case (state)
            BLANK: if (blank_end) state_next = SHOW;
            SHOW:  if (slot_end)  state_next = BLANK;
            default: state_next = BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt <= '0;
            digit    <= '0;
        end else begin
            slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
            if (slot_end) begin
                digit <= (digit == DIG_LAST) ? '0 : digit + 1'b1;
            end
        end
    end

    // A load on the boundary cycle lands in pending after the old pending commits
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_value <= '0;
            pend_en    <= '0;
            pend_lz    <= 1'b0;
            pend_valid <= 1'b0;
            act_value  <= '0;
            act_en     <= '0;
            act_lz     <= 1'b0;
        end else begin
            if (boundary && pend_valid) begin
                act_value  <= pend_value;
                act_en     <= pend_en;
                act_lz     <= pend_lz;
                pend_valid <= 1'b0;
            end
            if (load) begin
                pend_value <= value_in;
                pend_en    <= digit_en_in;
                pend_lz    <= lz_suppress_in;
                pend_valid <= 1'b1;
            end
        end
    end

    // Suppress a digit when it and every digit above it hold zero; digit 0 always shows
    always_comb begin
        int unsigned idx;
        logic        zero_run;
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            idx      = NUM_DIGITS - 1 - k;
            zero_run = zero_run && (act_value[4*idx +: 4] == 4'h0);
            lz_mask[idx] = act_lz && zero_run && (idx != 0);
        end
    end

    assign cur_nibble = act_value[{digit, 2'b00} +: 4];

    decoder_7_seg u_decoder (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    // Output logic
    always_comb begin
        visible  = (state == SHOW) && act_en[digit] && !lz_mask[digit];
        seg_next = SEG_BLANK;
        an_next  = '1;
        if (visible) begin
            seg_next = dec_seg;
            an_next  = ~(NUM_DIGITS'(1) << digit);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_out    <= SEG_BLANK;
            an_out     <= '1;
            frame_done <= 1'b0;
        end else begin
            seg_out    <= seg_next;
            an_out     <= an_next;
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_seven_seg_scan_ctrl;

    localparam int N = 4;
    localparam int R = 8;
    localparam int B = 2;

    localparam logic [0:6] S_0   = 7'b0000001;
    localparam logic [0:6] S_1   = 7'b1001111;
    localparam logic [0:6] S_2   = 7'b0010010;
    localparam logic [0:6] S_4   = 7'b1001100;
    localparam logic [0:6] S_5   = 7'b0100100;
    localparam logic [0:6] S_6   = 7'b0100000;
    localparam logic [0:6] S_8   = 7'b0000000;
    localparam logic [0:6] S_9   = 7'b0000100;
    localparam logic [0:6] S_A   = 7'b0001000;
    localparam logic [0:6] S_F   = 7'b0111000;
    localparam logic [0:6] S_OFF = 7'b1111111;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   value_in;
    logic [3:0]    digit_en_in;
    logic          lz_suppress_in;
    logic          load;
    logic [0:6]    seg_out;
    logic [3:0]    an_out;
    logic          frame_done;

    int n_asserts = 0;
    int n_fails   = 0;
    int cyc       = 0;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (R),
        .BLANK_CYCLES (B)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .value_in       (value_in),
        .digit_en_in    (digit_en_in),
        .lz_suppress_in (lz_suppress_in),
        .load           (load),
        .seg_out        (seg_out),
        .an_out         (an_out),
        .frame_done     (frame_done)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic next_cycle();
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_outputs(input string tag, input logic [0:6] es,
                                 input logic [3:0] ea, input logic ef);
        n_asserts++;
        assert (seg_out === es) else begin
            n_fails++;
            $error("FAIL %s seg_out cycle %0d: observed %b expected %b", tag, cyc, seg_out, es);
        end
        n_asserts++;
        assert (an_out === ea) else begin
            n_fails++;
            $error("FAIL %s an_out cycle %0d: observed %b expected %b", tag, cyc, an_out, ea);
        end
        n_asserts++;
        assert (frame_done === ef) else begin
            n_fails++;
            $error("FAIL %s frame_done cycle %0d: observed %b expected %b", tag, cyc, frame_done, ef);
        end
    endtask

    // l = {lz, en[3:0], value[15:0]}
    task automatic drive_load(input logic [20:0] l);
        {lz_suppress_in, digit_en_in, value_in} = l;
        load = 1'b1;
    endtask

    // Entered at the negedge of the first cycle of a frame; checks the 32 output
    // cycles that reflect that frame. Loads fire in frame cycle ka-1 / kb-1 (0 = none).
    task automatic check_frame(input string tag,
                               input logic [0:6] s3, input logic [0:6] s2,
                               input logic [0:6] s1, input logic [0:6] s0,
                               input logic [3:0] lit,
                               input int ka, input logic [20:0] la,
                               input int kb, input logic [20:0] lb);
        logic [0:6] segs [4];
        logic [0:6] es;
        logic [3:0] ea;
        int         p;
        int         dg;
        segs[0] = s0;
        segs[1] = s1;
        segs[2] = s2;
        segs[3] = s3;
        for (int k = 1; k <= 32; k++) begin
            if (ka == k) drive_load(la);
            if (kb == k) drive_load(lb);
            next_cycle();
            load = 1'b0;
            p  = (k - 1) % R;
            dg = (k - 1) / R;
            if (p >= B && lit[dg]) begin
                es = segs[dg];
                ea = ~(4'b0001 << dg);
            end else begin
                es = S_OFF;
                ea = 4'hF;
            end
            check_outputs(tag, es, ea, k == 32);
        end
    endtask

    initial begin
        rst            = 1'b1;
        load           = 1'b0;
        value_in       = '0;
        digit_en_in    = '0;
        lz_suppress_in = 1'b0;

        repeat (5) @(posedge clk);
        @(negedge clk);
        check_outputs("reset", S_OFF, 4'hF, 1'b0);
        rst = 1'b0;
        cyc = 0;

        check_frame("dark_f0",  S_OFF, S_OFF, S_OFF, S_OFF, 4'b0000, 4, {1'b0, 4'hF, 16'h12AF}, 0, '0);
        check_frame("hex12AF",  S_1, S_2, S_A, S_F, 4'b1111, 5, {1'b1, 4'hF, 16'h0040}, 0, '0);
        check_frame("lz0040",   S_OFF, S_OFF, S_4, S_0, 4'b0011, 5, {1'b1, 4'hF, 16'h0000}, 0, '0);
        check_frame("lz0000",   S_OFF, S_OFF, S_OFF, S_0, 4'b0001, 5, {1'b0, 4'hF, 16'h2222}, 0, '0);
        check_frame("hold2222", S_2, S_2, S_2, S_2, 4'b1111, 9, {1'b0, 4'hF, 16'h1111}, 0, '0);
        check_frame("show1111", S_1, S_1, S_1, S_1, 4'b1111,
                    3, {1'b0, 4'hF, 16'h3333}, 20, {1'b0, 4'hF, 16'h4444});
        check_frame("lastwins", S_4, S_4, S_4, S_4, 4'b1111,
                    10, {1'b0, 4'hF, 16'h6666}, 32, {1'b0, 4'hF, 16'h5555});
        check_frame("bnd_prev", S_6, S_6, S_6, S_6, 4'b1111, 0, '0, 0, '0);
        check_frame("bnd_new",  S_5, S_5, S_5, S_5, 4'b1111, 2, {1'b0, 4'b0101, 16'h8888}, 0, '0);
        check_frame("en0101",   S_OFF, S_8, S_OFF, S_8, 4'b0101, 5, {1'b1, 4'hF, 16'h0405}, 0, '0);
        check_frame("lz0405",   S_OFF, S_4, S_0, S_5, 4'b0111, 0, '0, 0, '0);

        // Frame 11 starts at cycle 352: queue a load, then pulse rst mid-slot 2
        next_cycle();
        next_cycle();
        drive_load({1'b0, 4'hF, 16'h7777});
        next_cycle();
        load = 1'b0;
        while (cyc < 352 + 7) next_cycle();
        check_outputs("pre_rst", S_5, 4'b1110, 1'b0);
        while (cyc < 352 + 18) next_cycle();
        rst = 1'b1;
        next_cycle();
        check_outputs("post_rst", S_OFF, 4'hF, 1'b0);
        rst = 1'b0;
        cyc = 0;

        check_frame("rst_dark0", S_OFF, S_OFF, S_OFF, S_OFF, 4'b0000, 0, '0, 0, '0);
        check_frame("rst_dark1", S_OFF, S_OFF, S_OFF, S_OFF, 4'b0000, 6, {1'b0, 4'hF, 16'h9999}, 0, '0);
        check_frame("rst_reload", S_9, S_9, S_9, S_9, 4'b1111, 0, '0, 0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
